// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 multiply/divide unit.
// Contents:
//   MDU_OP_WIDTH and the eight MDU_OP_* operation encodings
//   mdu_state_e -- FSM state encoding used by jedro_1_muldiv
//   helpers that decode operand signedness and the mul/div class of an op
package jedro_1_defines;

  localparam int MDU_OP_WIDTH = 3;

  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MUL    = 3'b000;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULH   = 3'b001;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIV    = 3'b100;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_REM    = 3'b110;
  localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_BUSY = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

  // Division ops occupy the upper half of the encoding space.
  function automatic logic mdu_is_div(input logic [MDU_OP_WIDTH-1:0] op);
    return op[2];
  endfunction

  // Operand A is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic mdu_a_signed(input logic [MDU_OP_WIDTH-1:0] op);
    logic s;
    case (op)
      MDU_OP_MULHU, MDU_OP_DIVU, MDU_OP_REMU: s = 1'b0;
      default:                                s = 1'b1;
    endcase
    return s;
  endfunction

  // Operand B is signed for MUL, MULH, DIV and REM.
  function automatic logic mdu_b_signed(input logic [MDU_OP_WIDTH-1:0] op);
    logic s;
    case (op)
      MDU_OP_MULHSU, MDU_OP_MULHU, MDU_OP_DIVU, MDU_OP_REMU: s = 1'b0;
      default:                                              s = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/jedro_1_muldiv_dp.sv
// Iterative datapath of the jedro_1 multiply/divide unit.
// Multiply: radix-2 shift-add on operand magnitudes into a 2*DATA_WIDTH
// accumulator. Divide: restoring division on magnitudes, remainder in the
// upper half and quotient in the lower half of the same accumulator.
// Sign correction is applied combinationally to the post-step value so the
// controller can register the final result on the last iteration edge.
// Ports:
//   clk_i   clock
//   load_i  capture op/operands and initialise the accumulator
//   step_i  perform one iteration
//   op_i    operation code (MDU_OP_*), sampled on load_i
//   opa_i   operand A, sampled on load_i
//   opb_i   operand B, sampled on load_i
//   res_o   sign-corrected result of the accumulator after the current step
module jedro_1_muldiv_dp
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [MDU_OP_WIDTH-1:0] op_i,
  input  logic [DATA_WIDTH-1:0]   opa_i,
  input  logic [DATA_WIDTH-1:0]   opb_i,
  output logic [DATA_WIDTH-1:0]   res_o
);

  localparam int DW = DATA_WIDTH;

  function automatic logic [DW-1:0] neg_n(input logic [DW-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*DW-1:0] neg_w(input logic [2*DW-1:0] x);
    return -x;
  endfunction

  logic [MDU_OP_WIDTH-1:0] op_q;
  logic [2*DW-1:0]         acc_q;
  logic [DW-1:0]           opr_q;
  logic [DW-1:0]           opa_q;
  logic                    neg_q;
  logic                    rneg_q;
  logic                    div0_q;

  logic                    a_neg, b_neg;
  logic [DW-1:0]           a_mag, b_mag;
  logic [DW:0]             mul_sum, r_sh, r_diff;
  logic [2*DW-1:0]         acc_step;
  logic [2*DW-1:0]         prod;

  always_comb begin
    a_neg = mdu_a_signed(op_i) & opa_i[DW-1];
    b_neg = mdu_b_signed(op_i) & opb_i[DW-1];
    a_mag = a_neg ? neg_n(opa_i) : opa_i;
    b_mag = b_neg ? neg_n(opb_i) : opb_i;
  end

  // One iteration: shift-add for multiply, shift-subtract-restore for divide.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opr_q} : {(DW+1){1'b0}});
    r_sh    = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    r_diff  = r_sh - {1'b0, opr_q};
    if (mdu_is_div(op_q)) begin
      if (!r_diff[DW]) acc_step = {r_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
      else             acc_step = {r_sh[DW-1:0], acc_q[DW-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[DW-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      op_q   <= op_i;
      opa_q  <= opa_i;
      div0_q <= (opb_i == {DW{1'b0}});
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      if (mdu_is_div(op_i)) begin
        acc_q <= {{DW{1'b0}}, a_mag};
        opr_q <= b_mag;
      end else begin
        acc_q <= {{DW{1'b0}}, b_mag};
        opr_q <= a_mag;
      end
    end else if (step_i) begin
      acc_q <= acc_step;
    end
  end

  // Divide-by-zero bypasses sign correction: all-ones quotient, dividend remainder.
  always_comb begin
    prod = neg_q ? neg_w(acc_step) : acc_step;
    case (op_q)
      MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU:
        res_o = prod[2*DW-1:DW];
      MDU_OP_DIV, MDU_OP_DIVU:
        res_o = div0_q ? {DW{1'b1}}
                       : (neg_q ? neg_n(acc_step[DW-1:0]) : acc_step[DW-1:0]);
      MDU_OP_REM, MDU_OP_REMU:
        res_o = div0_q ? opa_q
                       : (rneg_q ? neg_n(acc_step[2*DW-1:DW]) : acc_step[2*DW-1:DW]);
      default:
        res_o = prod[DW-1:0];
    endcase
  end

endmodule

// File: rtl/jedro_1_muldiv.sv
// jedro_1 multiply/divide unit: controller (FSM, iteration counter,
// handshake) around the iterative datapath jedro_1_muldiv_dp.
// A request is accepted in IDLE, iterates DATA_WIDTH cycles in BUSY and
// presents a one-cycle valid_o in DONE. Results stay on res_o until the next
// completed operation or reset.
// Ports:
//   clk_i, rstn_i         clock, synchronous active-low reset
//   valid_i / ready_o     request handshake (ready only in IDLE)
//   op_sel_i              operation (MDU_OP_*)
//   opa_i, opb_i          operands
//   reg_dest_addr_i/_o    destination register, captured / presented
//   reg_wb_i/_o           writeback flag, captured / presented
//   flush_i               abort in-flight operation
//   valid_o, res_o        result strobe and value
module jedro_1_muldiv
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [MDU_OP_WIDTH-1:0]   op_sel_i,
  input  logic [DATA_WIDTH-1:0]     opa_i,
  input  logic [DATA_WIDTH-1:0]     opb_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic                      reg_wb_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  output logic [DATA_WIDTH-1:0]     res_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic                      reg_wb_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  mdu_state_e                state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      valid_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic                      wb_q;
  logic [DATA_WIDTH-1:0]     dp_res;
  logic                      accept, step, last;

  assign ready_o = (state_q == MDU_IDLE);
  // A flush coinciding with a request keeps the unit idle.
  assign accept  = valid_i & ready_o & ~flush_i;
  assign step    = (state_q == MDU_BUSY) & ~flush_i;
  assign last    = (cnt_q == CNT_W'(1));
  // A flush raised during DONE withdraws the pulse in that same cycle.
  assign valid_o = valid_q & ~flush_i;

  jedro_1_muldiv_dp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_dp (
    .clk_i  (clk_i),
    .load_i (accept),
    .step_i (step),
    .op_i   (op_sel_i),
    .opa_i  (opa_i),
    .opb_i  (opb_i),
    .res_o  (dp_res)
  );

  always_ff @(posedge clk_i) begin
    if (accept) begin
      dest_q <= reg_dest_addr_i;
      wb_q   <= reg_wb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= MDU_IDLE;
      cnt_q           <= '0;
      valid_q         <= 1'b0;
      res_o           <= '0;
      reg_dest_addr_o <= '0;
      reg_wb_o        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (accept) begin
            state_q <= MDU_BUSY;
            cnt_q   <= CNT_W'(DATA_WIDTH);
          end
        end
        MDU_BUSY: begin
          if (flush_i) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last) begin
              state_q         <= MDU_DONE;
              valid_q         <= 1'b1;
              res_o           <= dp_res;
              reg_dest_addr_o <= dest_q;
              reg_wb_o        <= wb_q;
            end
          end
        end
        MDU_DONE: state_q <= MDU_IDLE;
        default:  state_q <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_muldiv.sv
module tb_jedro_1_muldiv;
  import jedro_1_defines::*;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_sel_i = '0;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic [4:0]  reg_dest_addr_i = '0;
  logic        reg_wb_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic [31:0] res_o;
  logic [4:0]  reg_dest_addr_o;
  logic        reg_wb_o;

  jedro_1_muldiv #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_sel_i(op_sel_i), .opa_i(opa_i), .opb_i(opb_i),
    .reg_dest_addr_i(reg_dest_addr_i), .reg_wb_i(reg_wb_i), .flush_i(flush_i),
    .valid_o(valid_o), .res_o(res_o), .reg_dest_addr_o(reg_dest_addr_o),
    .reg_wb_o(reg_wb_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        wb;
    int          due;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          pc = 0;
  logic [31:0] last_res;
  logic [4:0]  last_dest;

  always @(posedge clk) pc <= pc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid_o pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid_o=1 res=0x%08h expected no result", res_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_res"}, res_o, e.res);
        chk({e.name, "_dest"}, 32'(reg_dest_addr_o), 32'(e.dest));
        chk({e.name, "_wb"}, 32'(reg_wb_o), 32'(e.wb));
        chk({e.name, "_latency"}, 32'(pc), 32'(e.due));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] dest, input logic wb,
                       input logic [31:0] exp_res, input bit expect_res);
    int w;
    exp_t e;
    w = 0;
    while (!ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ready_o) chk({name, "_ready_timeout"}, 32'(ready_o), 32'd1);
    op_sel_i = op; opa_i = a; opb_i = b;
    reg_dest_addr_i = dest; reg_wb_i = wb; valid_i = 1'b1;
    if (expect_res) begin
      e.res = exp_res; e.dest = dest; e.wb = wb; e.due = pc + 33; e.name = name;
      sb.push_back(e);
      last_res = exp_res; last_dest = dest;
    end
    @(negedge clk);
    valid_i = 1'b0;
    // Scramble inputs after acceptance; the unit must not see them.
    op_sel_i = 3'(MDU_OP_DIVU); opa_i = $urandom; opb_i = $urandom;
    reg_dest_addr_i = 5'(~dest); reg_wb_i = ~wb;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_drain_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_res", res_o, 32'd0);
    chk("reset_dest", 32'(reg_dest_addr_o), 32'd0);
    chk("reset_wb", 32'(reg_wb_o), 32'd0);
    rstn_i = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(ready_o), 32'd1);

    issue("mul_7_m3",     MDU_OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  1'b1, 32'hFFFFFFEB, 1);
    issue("mulh_min",     MDU_OP_MULH,   32'h80000000, 32'h80000000, 5'd6,  1'b0, 32'h40000000, 1);
    issue("mulhu_max",    MDU_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  1'b1, 32'hFFFFFFFE, 1);
    issue("mulhsu_m1_2",  MDU_OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd8,  1'b1, 32'hFFFFFFFF, 1);
    issue("mulhu_carry",  MDU_OP_MULHU,  32'h80000000, 32'd2,        5'd9,  1'b1, 32'h00000001, 1);
    issue("mul_small",    MDU_OP_MUL,    32'h00012345, 32'h00000100, 5'd10, 1'b0, 32'h01234500, 1);
    issue("div_by0",      MDU_OP_DIV,    32'h12345678, 32'd0,        5'd11, 1'b1, 32'hFFFFFFFF, 1);
    issue("remu_by0",     MDU_OP_REMU,   32'h12345678, 32'd0,        5'd12, 1'b1, 32'h12345678, 1);
    issue("div_neg_by0",  MDU_OP_DIV,    32'hFFFFFFF9, 32'd0,        5'd13, 1'b1, 32'hFFFFFFFF, 1);
    issue("rem_neg_by0",  MDU_OP_REM,    32'hFFFFFFF9, 32'd0,        5'd14, 1'b1, 32'hFFFFFFF9, 1);
    issue("div_ovf",      MDU_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd15, 1'b1, 32'h80000000, 1);
    issue("rem_ovf",      MDU_OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b0, 32'h00000000, 1);
    issue("div_m7_2",     MDU_OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd17, 1'b1, 32'hFFFFFFFD, 1);
    issue("rem_m7_2",     MDU_OP_REM,    32'hFFFFFFF9, 32'd2,        5'd18, 1'b1, 32'hFFFFFFFF, 1);
    issue("divu_big",     MDU_OP_DIVU,   32'hFFFFFFFF, 32'h10,       5'd19, 1'b1, 32'h0FFFFFFF, 1);
    issue("remu_big",     MDU_OP_REMU,   32'hFFFFFFFF, 32'h10,       5'd20, 1'b1, 32'h0000000F, 1);
    drain("directed");

    // Results must hold after the pulse.
    repeat (5) @(negedge clk);
    chk("hold_res", res_o, last_res);
    chk("hold_dest", 32'(reg_dest_addr_o), 32'(last_dest));

    // Flush in the 10th BUSY cycle: no result, ready next cycle.
    issue("flushed", MDU_OP_MUL, 32'd3, 32'd4, 5'd21, 1'b1, 32'd12, 0);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 32'd1);
    repeat (40) @(negedge clk);
    issue("divu_100_7", MDU_OP_DIVU, 32'd100, 32'd7, 5'd22, 1'b1, 32'd14, 1);
    drain("after_flush");

    // valid_i held high with changing inputs during BUSY: a single result.
    begin
      exp_t e;
      op_sel_i = MDU_OP_MUL; opa_i = 32'd7; opb_i = 32'd6;
      reg_dest_addr_i = 5'd23; reg_wb_i = 1'b1; valid_i = 1'b1;
      e.res = 32'd42; e.dest = 5'd23; e.wb = 1'b1; e.due = pc + 33; e.name = "held_valid";
      sb.push_back(e);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        op_sel_i = 3'($urandom); opa_i = $urandom; opb_i = $urandom;
        reg_dest_addr_i = 5'($urandom);
      end
      valid_i = 1'b0;
    end
    drain("held_valid");
    repeat (10) @(negedge clk);

    // Reset mid-BUSY: outputs cleared, no result afterwards.
    issue("reset_abort", MDU_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd24, 1'b1, 32'd0, 0);
    repeat (14) @(negedge clk);
    rstn_i = 1'b0;
    @(negedge clk);
    chk("midreset_valid", 32'(valid_o), 32'd0);
    chk("midreset_res", res_o, 32'd0);
    chk("midreset_dest", 32'(reg_dest_addr_o), 32'd0);
    chk("midreset_wb", 32'(reg_wb_o), 32'd0);
    rstn_i = 1'b1;
    @(negedge clk);
    chk("midreset_ready", 32'(ready_o), 32'd1);
    repeat (40) @(negedge clk);
    issue("mul_post_reset", MDU_OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd25, 1'b0, 32'h00000001, 1);
    drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
